// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// Instruction fetch unit: one outstanding memory request feeding a single-entry
// instruction register, with static branch prediction and flush/discard handling.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_rsp_valid,
   output logic        ifu_rsp_ready,
   input  logic [31:0] ifu_rsp_instr,
   input  logic        ifu_rsp_err,
   input  logic        i_flush_req,
   input  logic [31:0] i_flush_pc,
   output logic        o_ir_valid,
   input  logic        o_ir_ready,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_prdt_taken,
   output logic        o_bus_err
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 7;

   localparam logic [OPW-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPW-1:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HALT = 2'd3
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            prdt;
      logic            bus_err;
   } ir_t;

   state_e          state_q,    state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            discard_q,  discard_d;
   logic            ir_valid_q, ir_valid_d;
   ir_t             ir_q,       ir_d;

   logic            req_fire;
   logic            rsp_fire;
   logic            rsp_load;
   logic [OPW-1:0]  opcode;
   logic [XLEN-1:0] j_imm;
   logic [XLEN-1:0] b_imm;
   logic [XLEN-1:0] pc_off;
   logic [XLEN-1:0] next_pc;
   logic            prdt_taken;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

   assign req_fire = ifu_req_valid & ifu_req_ready;
   assign rsp_fire = ifu_rsp_valid & ifu_rsp_ready;
   // A response only reaches the IR when it is neither stale nor killed by a same-cycle flush
   assign rsp_load = rsp_fire & ~discard_q & ~i_flush_req;

   // Static prediction: jal and backward branches taken, everything else falls through
   always_comb begin
      opcode     = ifu_rsp_instr[OPW-1:0];
      j_imm      = {{12{ifu_rsp_instr[31]}}, ifu_rsp_instr[19:12], ifu_rsp_instr[20],
                    ifu_rsp_instr[30:21], 1'b0};
      b_imm      = {{20{ifu_rsp_instr[31]}}, ifu_rsp_instr[7], ifu_rsp_instr[30:25],
                    ifu_rsp_instr[11:8], 1'b0};
      prdt_taken = 1'b0;
      pc_off     = XLEN'(4);
      if (opcode == OPC_JAL) begin
         prdt_taken = 1'b1;
         pc_off     = j_imm;
      end else if ((opcode == OPC_BRANCH) && ifu_rsp_instr[31]) begin
         prdt_taken = 1'b1;
         pc_off     = b_imm;
      end
      next_pc = word_align(fetch_pc_q + pc_off);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
      end
   end

   // FSM next state; a flush overrides every other event
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      if (i_flush_req) begin
         case (state_q)
            ST_IDLE, ST_HALT: state_d = ST_REQ;
            ST_REQ: begin
               if (req_fire) begin
                  state_d   = ST_WAIT;
                  discard_d = 1'b1;
               end else begin
                  state_d   = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (rsp_fire) begin
                  state_d   = ST_REQ;
                  discard_d = 1'b0;
               end else begin
                  state_d   = ST_WAIT;
                  discard_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
               if (req_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (rsp_fire) begin
                  if (discard_q) begin
                     state_d   = ST_REQ;
                     discard_d = 1'b0;
                  end else if (ifu_rsp_err) begin
                     state_d   = ST_HALT;
                  end else begin
                     state_d   = ST_REQ;
                  end
               end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs; a stale response is always drained regardless of IR occupancy
   always_comb begin
      ifu_req_valid = 1'b0;
      ifu_rsp_ready = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_REQ:  ifu_req_valid = 1'b1;
            ST_WAIT: ifu_rsp_ready = discard_q | ~ir_valid_q | o_ir_ready;
            default: ;
         endcase
      end
   end

   // Fetch PC and instruction register next values
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      ir_valid_d = ir_valid_q & ~o_ir_ready;
      ir_d       = ir_q;
      if (i_flush_req) begin
         fetch_pc_d   = word_align(i_flush_pc);
         ir_valid_d   = 1'b0;
         ir_d.bus_err = 1'b0;
      end else if (rsp_load) begin
         ir_valid_d = 1'b1;
         if (ifu_rsp_err) begin
            ir_d = '{instr: '0, pc: fetch_pc_q, prdt: 1'b0, bus_err: 1'b1};
         end else begin
            ir_d       = '{instr: ifu_rsp_instr, pc: fetch_pc_q, prdt: prdt_taken, bus_err: 1'b0};
            fetch_pc_d = next_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         ir_valid_q <= 1'b0;
         ir_q       <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         ir_valid_q <= ir_valid_d;
         ir_q       <= ir_d;
      end
   end

   assign ifu_req_addr = fetch_pc_q;
   assign o_ir_valid   = ir_valid_q;
   assign o_instr      = ir_q.instr;
   assign o_pc         = ir_q.pc;
   assign o_prdt_taken = ir_q.prdt;
   assign o_bus_err    = ir_q.bus_err;

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
// Bench for ifu_fetch: directed vector table and corner sequences, then a randomized
// run against an instruction-stream model driven by a generated program image.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_rsp_valid, ifu_rsp_ready;
   logic [31:0] ifu_rsp_instr;
   logic        ifu_rsp_err;
   logic        i_flush_req;
   logic [31:0] i_flush_pc;
   logic        o_ir_valid, o_ir_ready;
   logic [31:0] o_instr, o_pc;
   logic        o_prdt_taken, o_bus_err;

   ifu_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
      .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
      .i_flush_req(i_flush_req), .i_flush_pc(i_flush_pc),
      .o_ir_valid(o_ir_valid), .o_ir_ready(o_ir_ready),
      .o_instr(o_instr), .o_pc(o_pc), .o_prdt_taken(o_prdt_taken), .o_bus_err(o_bus_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory model controls
   logic        rnd_mode   = 1'b0;
   logic        mem_accept = 1'b0;
   logic        hold_rsp   = 1'b0;
   logic [31:0] dir_instr  = 32'h0000_0013;
   logic        dir_err    = 1'b0;
   logic        pend       = 1'b0;
   logic [31:0] paddr      = '0;
   int          pcnt       = 0;

   // program image with the intended control-flow effect of each word
   logic [31:0] rom_instr [64];
   logic        rom_taken [64];
   logic [31:0] rom_off   [64];

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        prdt;
   } exp_t;
   exp_t sb_q[$];
   exp_t e;

   typedef struct {
      logic [31:0] flush_pc;
      logic [31:0] instr;
      logic [31:0] exp_pc;
      logic        prdt;
      logic [31:0] next;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush(input logic [31:0] pc);
      i_flush_pc  = pc;
      i_flush_req = 1'b1;
      tick();
      i_flush_req = 1'b0;
   endtask

   task automatic wait_ir(input string name, input int bound);
      int n = 0;
      while (!o_ir_valid && n < bound) begin
         tick();
         n++;
      end
      chk(name, o_ir_valid, 1);
   endtask

   task automatic wait_req(input logic lvl, input string name, input int bound);
      int n = 0;
      while (ifu_req_valid !== lvl && n < bound) begin
         tick();
         n++;
      end
      chk(name, ifu_req_valid, lvl);
   endtask

   function automatic logic [31:0] enc_jal(input int imm);
      logic [20:0] v;
      v = 21'(imm);
      return {v[20], v[10:1], v[11], v[19:12], 5'd0, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_br(input int imm);
      logic [12:0] v;
      v = 13'(imm);
      return {v[12], v[10:5], 5'd0, 5'd0, 3'b000, v[4:1], v[11], 7'b1100011};
   endfunction

   // Memory: drives at negedge, observes handshakes just after
   initial begin : mem_model
      int rnd;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend          = 1'b0;
            pcnt          = 0;
            ifu_req_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            ifu_rsp_err   = 1'b0;
         end else begin
            rnd           = int'($urandom_range(0, 99));
            ifu_req_ready = rnd_mode ? (rnd < 60) : mem_accept;
            ifu_rsp_valid = 1'b0;
            if (pend) begin
               if (pcnt > 0) begin
                  pcnt--;
               end else if (!hold_rsp) begin
                  ifu_rsp_valid = 1'b1;
                  ifu_rsp_instr = rnd_mode ? rom_instr[paddr[7:2]] : dir_instr;
                  ifu_rsp_err   = rnd_mode ? 1'b0 : dir_err;
               end
            end
         end
         #1;
         if (rst_n) begin
            if (ifu_req_valid && ifu_req_ready) begin
               chk("single_outstanding", 32'(pend), 0);
               pend  = 1'b1;
               paddr = ifu_req_addr;
               pcnt  = rnd_mode ? int'($urandom_range(0, 3)) : 0;
            end else if (ifu_rsp_valid && ifu_rsp_ready) begin
               pend = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] r;
      logic [31:0] exp_pc;
      logic [31:0] prev_addr;
      logic        prev_stall;
      logic        fl;
      int          k, imm, cnt;

      for (int i = 0; i < 64; i++) begin
         r = $urandom;
         k = int'($urandom_range(0, 5));
         case (k)
            0: begin rom_instr[i] = {r[31:7], 7'b0010011}; rom_taken[i] = 1'b0; rom_off[i] = 32'd4; end
            1: begin
               imm = (int'($urandom_range(0, 64)) - 32) * 4;
               rom_instr[i] = enc_jal(imm); rom_taken[i] = 1'b1; rom_off[i] = 32'(imm);
            end
            2: begin
               imm = -4 * int'($urandom_range(1, 40));
               rom_instr[i] = enc_br(imm); rom_taken[i] = 1'b1; rom_off[i] = 32'(imm);
            end
            3: begin
               imm = 4 * int'($urandom_range(1, 40));
               rom_instr[i] = enc_br(imm); rom_taken[i] = 1'b0; rom_off[i] = 32'd4;
            end
            4: begin
               rom_instr[i] = {r[31:20], 5'd1, 3'b000, 5'd0, 7'b1100111};
               rom_taken[i] = 1'b0; rom_off[i] = 32'd4;
            end
            default: begin rom_instr[i] = {r[31:7], 7'b0110111}; rom_taken[i] = 1'b0; rom_off[i] = 32'd4; end
         endcase
      end

      vecs[0] = '{32'h0000_0100, 32'hFE00_0EE3, 32'h0000_0100, 1'b1, 32'h0000_00FC};
      vecs[1] = '{32'h0000_0100, 32'h0000_0463, 32'h0000_0100, 1'b0, 32'h0000_0104};
      vecs[2] = '{32'h0000_0200, 32'h0200_006F, 32'h0000_0200, 1'b1, 32'h0000_0220};
      vecs[3] = '{32'h0000_0200, 32'h0000_8067, 32'h0000_0200, 1'b0, 32'h0000_0204};
      vecs[4] = '{32'hFFFF_FFFC, 32'h0080_006F, 32'hFFFF_FFFC, 1'b1, 32'h0000_0004};
      vecs[5] = '{32'h0000_0000, 32'hFE00_0EE3, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
      vecs[6] = '{32'h0000_1000, 32'hFF1F_F06F, 32'h0000_1000, 1'b1, 32'h0000_0FF0};
      vecs[7] = '{32'h0000_0502, 32'h0000_1463, 32'h0000_0500, 1'b0, 32'h0000_0504};

      rst_n       = 1'b0;
      i_flush_req = 1'b0;
      i_flush_pc  = '0;
      o_ir_ready  = 1'b0;
      repeat (3) tick();
      chk("rst_req_valid", ifu_req_valid, 0);
      chk("rst_rsp_ready", ifu_rsp_ready, 0);
      chk("rst_ir_valid", o_ir_valid, 0);
      chk("rst_pc", o_pc, 0);
      chk("rst_instr", o_instr, 0);
      chk("rst_bus_err", o_bus_err, 0);

      // first fetch after reset with zero-wait memory
      dir_instr  = 32'h0000_0013;
      mem_accept = 1'b1;
      rst_n      = 1'b1;
      chk("idle_no_req", ifu_req_valid, 0);
      tick();
      chk("first_req_valid", ifu_req_valid, 1);
      chk("first_req_addr", ifu_req_addr, RESET_PC);
      tick();
      tick();
      mem_accept = 1'b0;
      chk("first_ir_latency", o_ir_valid, 1);
      chk("first_ir_instr", o_instr, 32'h13);
      chk("first_ir_pc", o_pc, RESET_PC);
      chk("first_ir_prdt", o_prdt_taken, 0);
      chk("second_req_addr", ifu_req_addr, RESET_PC + 32'd4);

      // prediction / next-PC table
      foreach (vecs[i]) begin
         mem_accept = 1'b0;
         dir_instr  = vecs[i].instr;
         do_flush(vecs[i].flush_pc);
         chk($sformatf("vec%0d_req_addr", i), ifu_req_addr, vecs[i].exp_pc);
         mem_accept = 1'b1;
         wait_ir($sformatf("vec%0d_ir_timeout", i), 8);
         mem_accept = 1'b0;
         chk($sformatf("vec%0d_instr", i), o_instr, vecs[i].instr);
         chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_prdt", i), o_prdt_taken, vecs[i].prdt);
         chk($sformatf("vec%0d_next_valid", i), ifu_req_valid, 1);
         chk($sformatf("vec%0d_next_addr", i), ifu_req_addr, vecs[i].next);
      end

      // flush while waiting: late response is dropped
      dir_instr = 32'h0000_0013;
      do_flush(32'h0000_0600);
      hold_rsp   = 1'b1;
      mem_accept = 1'b1;
      wait_req(1'b0, "discard_enter_wait", 6);
      mem_accept = 1'b0;
      tick();
      do_flush(32'h0000_0403);
      chk("discard_ir_valid", o_ir_valid, 0);
      chk("discard_stay_wait", ifu_req_valid, 0);
      hold_rsp = 1'b0;
      wait_req(1'b1, "discard_back_to_req", 6);
      chk("discard_ir_still_empty", o_ir_valid, 0);
      chk("discard_req_addr", ifu_req_addr, 32'h0000_0400);

      // flush on the same edge as a response: dropped and no discard left behind
      hold_rsp   = 1'b1;
      mem_accept = 1'b1;
      wait_req(1'b0, "coinc_enter_wait", 6);
      mem_accept = 1'b0;
      tick();
      i_flush_pc  = 32'h0000_0700;
      i_flush_req = 1'b1;
      hold_rsp    = 1'b0;
      tick();
      i_flush_req = 1'b0;
      chk("coinc_ir_valid", o_ir_valid, 0);
      chk("coinc_req_valid", ifu_req_valid, 1);
      chk("coinc_req_addr", ifu_req_addr, 32'h0000_0700);
      mem_accept = 1'b1;
      tick();
      tick();
      mem_accept = 1'b0;
      chk("coinc_next_loads", o_ir_valid, 1);
      chk("coinc_next_pc", o_pc, 32'h0000_0700);

      // decode backpressure with a response pending
      do_flush(32'h0000_0800);
      mem_accept = 1'b1;
      wait_ir("bp_first_ir", 8);
      chk("bp_first_pc", o_pc, 32'h0000_0800);
      wait_req(1'b0, "bp_second_req", 6);
      mem_accept = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ifu_rsp_ready || !o_ir_valid || o_pc !== 32'h0000_0800) cnt++;
      end
      chk("bp_stall_violations", 32'(cnt), 0);
      chk("bp_rsp_pending", ifu_rsp_valid, 1);
      o_ir_ready = 1'b1;
      #1;
      chk("bp_release_rsp_ready", ifu_rsp_ready, 1);
      tick();
      o_ir_ready = 1'b0;
      chk("bp_reload_valid", o_ir_valid, 1);
      chk("bp_reload_pc", o_pc, 32'h0000_0804);

      // bus error halts fetch until redirected
      dir_err = 1'b1;
      do_flush(32'h0000_0300);
      mem_accept = 1'b1;
      wait_ir("err_ir", 8);
      dir_err = 1'b0;
      chk("err_instr", o_instr, 0);
      chk("err_pc", o_pc, 32'h0000_0300);
      chk("err_bus_err", o_bus_err, 1);
      chk("err_prdt", o_prdt_taken, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ifu_req_valid) cnt++;
      end
      chk("err_halt_reqs", 32'(cnt), 0);
      mem_accept = 1'b0;
      do_flush(32'h0000_0080);
      chk("err_flush_bus_err", o_bus_err, 0);
      chk("err_flush_req_valid", ifu_req_valid, 1);
      chk("err_flush_req_addr", ifu_req_addr, 32'h0000_0080);

      // reset in the middle of an outstanding request
      mem_accept = 1'b1;
      wait_ir("mid_ir", 8);
      hold_rsp = 1'b1;
      wait_req(1'b0, "mid_wait", 6);
      mem_accept = 1'b0;
      rst_n      = 1'b0;
      o_ir_ready = 1'b1;
      #1;
      chk("mid_rst_rsp_ready", ifu_rsp_ready, 0);
      tick();
      o_ir_ready = 1'b0;
      hold_rsp   = 1'b0;
      chk("mid_rst_ir_valid", o_ir_valid, 0);
      chk("mid_rst_pc", o_pc, 0);
      chk("mid_rst_instr", o_instr, 0);
      tick();
      chk("mid_rst_req_valid", ifu_req_valid, 0);

      // randomized run against the program-image model
      rnd_mode   = 1'b1;
      rst_n      = 1'b1;
      exp_pc     = RESET_PC;
      prev_stall = 1'b0;
      prev_addr  = '0;
      sb_q.delete();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         o_ir_ready  = ($urandom_range(0, 99) < 70);
         fl          = ($urandom_range(0, 99) < 3);
         i_flush_req = fl;
         i_flush_pc  = $urandom;
         #2;
         if (prev_stall) begin
            chk("rnd_req_hold_valid", ifu_req_valid, 1);
            chk("rnd_req_hold_addr", ifu_req_addr, prev_addr);
         end
         prev_stall = ifu_req_valid && !ifu_req_ready && !fl;
         prev_addr  = ifu_req_addr;
         if (o_ir_valid && o_ir_ready) begin
            if (sb_q.size() == 0) begin
               chk("rnd_ir_unexpected_q", 32'(sb_q.size()), 1);
            end else begin
               e = sb_q.pop_front();
               chk("rnd_ir_instr", o_instr, e.instr);
               chk("rnd_ir_pc", o_pc, e.pc);
               chk("rnd_ir_prdt", o_prdt_taken, e.prdt);
               chk("rnd_ir_bus_err", o_bus_err, 0);
            end
         end
         if (ifu_req_valid && ifu_req_ready) begin
            chk("rnd_req_addr", ifu_req_addr, exp_pc);
            if (!fl) begin
               sb_q.push_back('{instr: rom_instr[exp_pc[7:2]], pc: exp_pc, prdt: rom_taken[exp_pc[7:2]]});
               exp_pc = exp_pc + rom_off[exp_pc[7:2]];
            end
         end
         if (fl) begin
            sb_q.delete();
            exp_pc = i_flush_pc & ~32'd3;
         end
      end
      i_flush_req = 1'b0;
      o_ir_ready  = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
